// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: symbolic instruction in, machine word plus IM address out.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_word, out_addr
  );
  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_word, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// MIPS instruction encoder with a single-entry output register and IM address counter.
// Optional macro INSTR_ENCODER_DELAY_SLOT_NOP_EN inserts a nop after every branch/jump.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 4096
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear,
  instr_encoder_if.slave bus,
  output logic           wrap,
  output logic           err,
  output logic [15:0]    count
);
  typedef enum logic {EMIT, SLOT} state_t;

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

  state_t      state;
  logic [31:0] enc;
  logic        legal, accept, fire, at_last;

  assign legal    = (bus.in_kind < 4'd12);
  assign bus.in_ready = !clear && (state == EMIT) && (!bus.out_valid || bus.out_ready);
  assign accept   = bus.in_valid && bus.in_ready;
  assign fire     = !clear && bus.out_valid && bus.out_ready;
  assign at_last  = (bus.out_addr == LAST_ADDR);

  always_comb begin
    enc = '0;
    case (bus.in_kind)
      4'd0:  enc = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'h20};
      4'd1:  enc = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'h22};
      4'd2:  enc = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm};
      4'd3:  enc = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
      4'd4:  enc = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
      4'd5:  enc = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
      4'd6:  enc = {6'h0F, 5'b0, bus.in_rt, bus.in_imm};
      4'd7:  enc = {6'h03, bus.in_target};
      4'd8:  enc = {6'h00, bus.in_rs, 15'b0, 6'h08};
      4'd9:  enc = {6'h02, bus.in_target};
      4'd10: enc = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
      default: enc = '0;
    endcase
  end

`ifdef INSTR_ENCODER_DELAY_SLOT_NOP_EN
  logic branch;
  assign branch = (bus.in_kind == 4'd5) || (bus.in_kind == 4'd7) ||
                  (bus.in_kind == 4'd8) || (bus.in_kind == 4'd9);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= EMIT;
      bus.out_valid <= 1'b0;
      bus.out_word  <= '0;
      bus.out_addr  <= BASE_ADDR;
      wrap         <= 1'b0;
      err          <= 1'b0;
      count        <= '0;
    end else if (clear) begin
      state        <= EMIT;
      bus.out_valid <= 1'b0;
      bus.out_word  <= '0;
      bus.out_addr  <= BASE_ADDR;
      wrap         <= 1'b0;
      err          <= 1'b0;
      count        <= '0;
    end else begin
      wrap <= 1'b0;
      if (fire) begin
        bus.out_addr <= at_last ? BASE_ADDR : bus.out_addr + 32'd4;
        wrap        <= at_last;
        if (count != 16'hFFFF) count <= count + 16'd1;
      end
      if (accept && !legal) err <= 1'b1;
      // Load and drain may coincide: the new word replaces the departing one.
      if (accept && legal) begin
        bus.out_valid <= 1'b1;
        bus.out_word  <= enc;
      end else if (fire) begin
        bus.out_valid <= 1'b0;
      end
`ifdef INSTR_ENCODER_DELAY_SLOT_NOP_EN
      // SLOT blocks intake, so the branch draining is the only event here.
      if (state == SLOT && fire) begin
        bus.out_valid <= 1'b1;
        bus.out_word  <= '0;
        state        <= EMIT;
      end else if (accept && branch) begin
        state <= SLOT;
      end
`endif
    end
  end
endmodule
